// File: rtl/inert_pkg.sv
`timescale 1ns/1ps
// inert_pkg
// Shared definitions for the inertial-sensor SPI serf model: the register
// address map and the frame-decoder state encoding.
package inert_pkg;

    localparam logic [6:0] INT1_CTRL     = 7'h0D;
    localparam logic [6:0] WHO_AM_I_ADDR = 7'h0F;
    localparam logic [6:0] CTRL2_G       = 7'h11;
    localparam logic [6:0] CTRL3_C       = 7'h14;
    localparam logic [6:0] OUTZ_L_G      = 7'h26;
    localparam logic [6:0] OUTZ_H_G      = 7'h27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } serf_state_t;

endpackage

// File: rtl/spi_serf_sync.sv
`timescale 1ns/1ps
// spi_serf_sync
// Brings the asynchronous SPI pins into the clk domain and produces
// single-clk edge strobes.
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   SS_n, SCLK, MOSI              raw SPI pins
//   sclk_rise, sclk_fall          one-clk strobes on synced SCLK edges
//   ss_fall, ss_rise              one-clk strobes on synced SS_n edges
//   mosi_s                        synchronized MOSI
module spi_serf_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sclk_d;
    logic                   ss_s;
    logic                   sclk_s;

    // The SS_n chain resets to 0 (not to its idle level of 1) so that a
    // reset released while a master still holds SS_n low produces no fall
    // strobe; the block then waits for a genuine new frame. The spurious
    // rise seen when SS_n is high after reset lands in IDLE, where it is
    // ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

endmodule

// File: rtl/inert_spi_serf.sv
`timescale 1ns/1ps
// inert_spi_serf
// SPI mode-0 responder modelling a 6-axis inertial sensor's gyro link.
// Decodes 16-bit R/nW frames, holds three config registers, serves the
// latest yaw-rate sample as two bytes with a read-coherency lock, and
// raises a level INT on new data.
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   SS_n, SCLK, MOSI, MISO        SPI link (MISO is 0 when not serving a read)
//   INT                           data-ready interrupt, active-high level
//   yaw_in, yaw_vld               new signed yaw sample and its one-clk strobe
//   int1_ctrl, ctrl2_g, ctrl3_c   current values of regs 0x0D, 0x11, 0x14
module inert_spi_serf
    import inert_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I    = 8'h6A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               MISO,
    output logic               INT,
    input  logic signed [15:0] yaw_in,
    input  logic               yaw_vld,
    output logic        [7:0]  int1_ctrl,
    output logic        [7:0]  ctrl2_g,
    output logic        [7:0]  ctrl3_c
);

    logic        sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
    serf_state_t state, state_nxt;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  cmd_byte;
    logic [7:0]  yaw_h, yaw_l;
    logic [15:0] pend_buf;
    logic        lock, pending;
    logic        commit, commit_wr, commit_rd;
    logic [6:0]  commit_addr;
    logic        capture;
    logic [15:0] cap_val;

    spi_serf_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .mosi_s    (mosi_s)
    );

    function automatic logic [7:0] read_mux(input logic [6:0] addr);
        case (addr)
            INT1_CTRL:     read_mux = int1_ctrl;
            WHO_AM_I_ADDR: read_mux = WHO_AM_I;
            CTRL2_G:       read_mux = ctrl2_g;
            CTRL3_C:       read_mux = ctrl3_c;
            OUTZ_L_G:      read_mux = yaw_l;
            OUTZ_H_G:      read_mux = yaw_h;
            default:       read_mux = 8'h00;
        endcase
    endfunction

    // ---- frame FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---- frame FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ss_fall) state_nxt = ADDR;
            ADDR: begin
                if (ss_rise)                            state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == 5'd7)  state_nxt = DATA;
            end
            DATA: begin
                if (ss_rise)                            state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == 5'd15) state_nxt = DONE;
            end
            DONE: if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- frame FSM: outputs ----
    always_comb begin
        MISO = 1'b0;
        if (state == DATA) MISO = tx_shift[7];
    end

    assign cmd_byte    = {rx_shift[6:0], mosi_s};
    assign commit      = (state == DONE) && ss_rise;
    assign commit_wr   = commit && !rx_shift[15];
    assign commit_rd   = commit && rx_shift[15];
    assign commit_addr = rx_shift[14:8];

    // ---- shift path ----
    // The fall that directly follows the 8th rise (bit_cnt == 8) must not
    // shift: the master samples tx_shift[7] on the 9th rise. Shifting
    // starts on the fall after the 9th rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (state == IDLE && ss_fall) begin
                bit_cnt <= '0;
            end else if ((state == ADDR || state == DATA) && sclk_rise) begin
                rx_shift <= {rx_shift[14:0], mosi_s};
                bit_cnt  <= bit_cnt + 5'd1;
            end

            if (state == ADDR && sclk_rise && bit_cnt == 5'd7)
                tx_shift <= cmd_byte[7] ? read_mux(cmd_byte[6:0]) : 8'h00;
            else if (state == DATA && sclk_fall && bit_cnt > 5'd8)
                tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // ---- register file commit ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl3_c   <= 8'h00;
        end else if (commit_wr) begin
            case (commit_addr)
                INT1_CTRL: int1_ctrl <= rx_shift[7:0];
                CTRL2_G:   ctrl2_g   <= rx_shift[7:0];
                CTRL3_C:   ctrl3_c   <= rx_shift[7:0];
                default:   ;
            endcase
        end
    end

    // A fresh sample wins over a pending one if both are available at once.
    always_comb begin
        capture = 1'b0;
        cap_val = pend_buf;
        if (!lock && yaw_vld) begin
            capture = 1'b1;
            cap_val = yaw_in;
        end else if (!lock && pending) begin
            capture = 1'b1;
        end
    end

    // ---- sample capture, lock and INT ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaw_h    <= 8'h00;
            yaw_l    <= 8'h00;
            pend_buf <= 16'h0000;
            pending  <= 1'b0;
            lock     <= 1'b0;
            INT      <= 1'b0;
        end else begin
            if (capture) begin
                yaw_h <= cap_val[15:8];
                yaw_l <= cap_val[7:0];
            end

            if (lock && yaw_vld) begin
                pend_buf <= yaw_in;
                pending  <= 1'b1;
            end else if (capture) begin
                pending  <= 1'b0;
            end

            if (commit_rd && commit_addr == OUTZ_L_G)      lock <= 1'b1;
            else if (commit_rd && commit_addr == OUTZ_H_G) lock <= 1'b0;

            if (capture && int1_ctrl[1])                   INT <= 1'b1;
            else if (commit_rd && commit_addr == OUTZ_H_G) INT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inert_spi_serf.sv
`timescale 1ns/1ps
module tb_inert_spi_serf;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               SS_n = 1'b1;
    logic               SCLK = 1'b0;
    logic               MOSI = 1'b0;
    logic               MISO;
    logic               INT;
    logic signed [15:0] yaw_in = 16'sh0000;
    logic               yaw_vld = 1'b0;
    logic [7:0]         int1_ctrl, ctrl2_g, ctrl3_c;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] frame;
        logic        is_rd;
        logic [7:0]  exp_rd;
        logic [7:0]  e_int1;
        logic [7:0]  e_ctrl2;
        logic [7:0]  e_ctrl3;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    inert_spi_serf #(.WHO_AM_I(8'h6A), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .INT       (INT),
        .yaw_in    (yaw_in),
        .yaw_vld   (yaw_vld),
        .int1_ctrl (int1_ctrl),
        .ctrl2_g   (ctrl2_g),
        .ctrl3_c   (ctrl3_c)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives nbits of a frame MSB first; SS_n is raised afterwards only when
    // 'release_ss' is set. Bits of the data phase are sampled from MISO just
    // before each rising SCLK edge, as a mode-0 master would.
    task automatic spi_xfer(input logic [15:0] frame, input int nbits,
                            input bit release_ss, output logic [7:0] rd);
        rd   = 8'h00;
        SS_n = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = frame[15-i];
            tick(6);
            if (i >= 8) rd = {rd[6:0], MISO};
            SCLK = 1'b1;
            tick(6);
            SCLK = 1'b0;
        end
        tick(6);
        if (release_ss) begin
            SS_n = 1'b1;
            MOSI = 1'b0;
            tick(6);
        end
    endtask

    task automatic do_read(input logic [15:0] frame, input logic [7:0] exp, input string name);
        logic [7:0] rd, e;
        exp_q.push_back(exp);
        spi_xfer(frame, 16, 1'b1, rd);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, rd);
        end else begin
            e = exp_q.pop_front();
            chk(name, {8'h00, rd}, {8'h00, e});
        end
    endtask

    task automatic do_write(input logic [15:0] frame);
        logic [7:0] rd;
        spi_xfer(frame, 16, 1'b1, rd);
    endtask

    task automatic send_yaw(input logic [15:0] v);
        yaw_in  = v;
        yaw_vld = 1'b1;
        tick(1);
        yaw_vld = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;

        vecs[0] = '{16'h8F00, 1'b1, 8'h6A, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{16'h0D02, 1'b0, 8'h00, 8'h02, 8'h00, 8'h00};
        vecs[2] = '{16'h1160, 1'b0, 8'h00, 8'h02, 8'h60, 8'h00};
        vecs[3] = '{16'h1440, 1'b0, 8'h00, 8'h02, 8'h60, 8'h40};
        vecs[4] = '{16'h8D00, 1'b1, 8'h02, 8'h02, 8'h60, 8'h40};
        vecs[5] = '{16'h9100, 1'b1, 8'h60, 8'h02, 8'h60, 8'h40};
        vecs[6] = '{16'h9400, 1'b1, 8'h40, 8'h02, 8'h60, 8'h40};
        vecs[7] = '{16'h0F55, 1'b0, 8'h00, 8'h02, 8'h60, 8'h40};
        vecs[8] = '{16'h8F00, 1'b1, 8'h6A, 8'h02, 8'h60, 8'h40};
        vecs[9] = '{16'hA000, 1'b1, 8'h00, 8'h02, 8'h60, 8'h40};

        // Reset state
        tick(3);
        chk("rst_miso", {15'd0, MISO}, 16'h0000);
        chk("rst_int", {15'd0, INT}, 16'h0000);
        chk("rst_int1_ctrl", {8'h00, int1_ctrl}, 16'h0000);
        chk("rst_ctrl2_g", {8'h00, ctrl2_g}, 16'h0000);
        chk("rst_ctrl3_c", {8'h00, ctrl3_c}, 16'h0000);
        rst_n = 1'b1;
        tick(4);

        // Register map vectors
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_rd) do_read(vecs[i].frame, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
            else               do_write(vecs[i].frame);
            chk($sformatf("vec%0d_int1", i), {8'h00, int1_ctrl}, {8'h00, vecs[i].e_int1});
            chk($sformatf("vec%0d_ctrl2", i), {8'h00, ctrl2_g}, {8'h00, vecs[i].e_ctrl2});
            chk($sformatf("vec%0d_ctrl3", i), {8'h00, ctrl3_c}, {8'h00, vecs[i].e_ctrl3});
            chk($sformatf("vec%0d_int", i), {15'd0, INT}, 16'h0000);
        end

        // Sample capture and INT
        send_yaw(16'hF123);
        chk("yaw1_int_set", {15'd0, INT}, 16'h0001);
        do_read(16'hA600, 8'h23, "yaw1_lo");
        chk("yaw1_int_after_lo", {15'd0, INT}, 16'h0001);
        do_read(16'hA700, 8'hF1, "yaw1_hi");
        chk("yaw1_int_clr", {15'd0, INT}, 16'h0000);

        // Coherency lock with newest-wins pending buffer
        do_read(16'hA600, 8'h23, "lock_lo");
        send_yaw(16'h1234);
        tick(2);
        send_yaw(16'h5678);
        chk("lock_no_int", {15'd0, INT}, 16'h0000);
        do_read(16'hA700, 8'hF1, "lock_hi_old");
        chk("unlock_int", {15'd0, INT}, 16'h0001);
        do_read(16'hA600, 8'h78, "unlock_lo");
        do_read(16'hA700, 8'h56, "unlock_hi");
        chk("unlock_int_clr", {15'd0, INT}, 16'h0000);

        // Aborted frames and INT enable behaviour
        send_yaw(16'hABCD);
        chk("abcd_int", {15'd0, INT}, 16'h0001);
        spi_xfer(16'hA700, 12, 1'b1, rd);
        chk("abort_rd_int_kept", {15'd0, INT}, 16'h0001);
        spi_xfer(16'h11FF, 10, 1'b1, rd);
        chk("abort_wr_ctrl2", {8'h00, ctrl2_g}, 16'h0060);
        do_read(16'h9100, 8'h60, "abort_then_rd");
        do_write(16'h0D00);
        chk("int1_cleared", {8'h00, int1_ctrl}, 16'h0000);
        chk("int_kept_after_disable", {15'd0, INT}, 16'h0001);
        send_yaw(16'h0BAD);
        do_read(16'hA600, 8'hAD, "dis_lo");
        do_read(16'hA700, 8'h0B, "dis_hi");
        chk("dis_int_clr", {15'd0, INT}, 16'h0000);
        send_yaw(16'h1111);
        tick(2);
        chk("dis_no_int", {15'd0, INT}, 16'h0000);

        // Reset in the middle of the address phase
        spi_xfer(16'h8F00, 4, 1'b0, rd);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_miso", {15'd0, MISO}, 16'h0000);
        chk("midrst_int", {15'd0, INT}, 16'h0000);
        chk("midrst_ctrl2", {8'h00, ctrl2_g}, 16'h0000);
        chk("midrst_ctrl3", {8'h00, ctrl3_c}, 16'h0000);
        rst_n = 1'b1;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b1;
            tick(6);
            SCLK = 1'b0;
            tick(6);
        end
        SS_n = 1'b1;
        tick(6);
        chk("midrst_ctrl2_idle", {8'h00, ctrl2_g}, 16'h0000);
        do_read(16'h8F00, 8'h6A, "midrst_whoami");
        do_read(16'hA600, 8'h00, "midrst_yaw_lo");
        do_read(16'h9400, 8'h00, "midrst_ctrl3_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
